approx_mul_arbiter: RTL
=======================

Name: approx_mul_arbiter

Overview:
- Shares one pipelined 16x16 approximate multiplier among NREQ independent requesters.
- Round-robin arbitration with per-requester valid/ready on the request and response sides.
- Registers operands into the multiplier and tracks in-flight operations with a tag pipeline.
- Steers each product back to its requester through a one-entry response buffer per requester.
- Sits between core-side accelerator clients and the single multiplier instance; the multiplier is instantiated by the parent and wired to the mul_* ports.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MUL_LAT, 1, clock edges from mul_a/mul_b change to mul_out valid (1 for the clocked 16-bit multiplier).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  request valid, bit i = requester i.
- req_ready  out  NREQ  one-hot grant, combinational.
- req_a  in  16*NREQ  operand A, slice [16i+15:16i].
- req_b  in  16*NREQ  operand B, same slicing.
- rsp_valid  out  NREQ  response valid per requester.
- rsp_ready  in  NREQ  response accept per requester.
- rsp_data  out  32*NREQ  product, slice [32i+31:32i].
- mul_a  out  16  registered operand A to the multiplier.
- mul_b  out  16  registered operand B to the multiplier.
- mul_out  in  32  multiplier result.
- mul_reset  out  1  active-high multiplier reset; equals ~resetn, asserts asynchronously.
- busy  out  1  high when any tag is in flight or any rsp_valid is set.
- op_count  out  32  count of accepted requests; wraps 0xFFFFFFFF->0.

Behaviour:
- Reset (resetn=0, async): rsp_valid=0, rsp_data=0, mul_a=0, mul_b=0, op_count=0, busy=0; tag pipeline and pending flags cleared; RR pointer=0. req_ready=0 while in reset.
- Reset mid-operation discards in-flight operations; no response is produced for them.
- Eligibility: requester i is eligible when req_valid[i]=1 and pending[i]=0.
- pending[i] is registered. It sets on the accept edge and clears on the edge where rsp_valid[i]&&rsp_ready[i].
- Result: at most one outstanding operation per requester.
- Arbitration: search eligible requesters starting at the RR pointer, wrapping modulo NREQ. The first hit gets req_ready[i]=1; all other req_ready bits are 0.
- req_ready is never asserted without the matching req_valid.
- On accept, the RR pointer becomes (i+1) mod NREQ; with no accept it holds.
- Issue: on accept, mul_a/mul_b load req_a/req_b slice i; otherwise they hold their last value (no toggling when idle).
- Tag pipeline: MUL_LAT+1 stages of {valid, index}; stage 0 loads on accept (valid=0 otherwise) and shifts every cycle.
- When the last stage is valid, mul_out is written into rsp_data slice [index] and rsp_valid[index] is set.
- Latency: accept at edge E0 -> rsp_valid high after edge E(MUL_LAT+1), i.e. 2 cycles for MUL_LAT=1.
- Throughput: one accept per cycle across distinct requesters.
- Response hold: rsp_data slice i is stable while rsp_valid[i]=1. It clears rsp_valid[i] on handshake; the data keeps its value.
- Write/consume collision on the same index is impossible by construction (pending). Any such event is a design bug.
- Same-cycle consume and new request from requester i: not eligible that cycle; earliest re-grant is the next cycle.
- op_count increments by 1 per accept.
- busy = |pending.

Test Plan:
- Single requester: requester 0 issues a=3, b=5 after reset -> req_ready[0] high that cycle; rsp_valid[0] high 2 cycles later with rsp_data[31:0]=15 (exact multiplier config); op_count=1.
- All four requesters valid in the same cycle, operands i+1 x 0x0100 -> grants in order 0,1,2,3 on consecutive cycles; responses arrive in the same order with 0x00000100, 0x200, 0x300, 0x400.
- Round-robin fairness: pointer at 2, requesters 0 and 3 valid -> requester 3 granted first, then 0.
- Backpressure: requester 1 holds rsp_ready=0 with a pending response -> req_ready[1] stays 0 despite a new valid, while others are still granted. After consume, the first re-grant comes the cycle after.
- Max operands 0xFFFF x 0xFFFF -> rsp_data=0xFFFE0001.
- Reset mid-flight: assert resetn=0 one cycle after accept -> all rsp_valid=0, op_count=0, mul_a=mul_b=0, mul_reset=1 immediately. No response appears after release.

Source files
------------

// File: rtl/approx_mul_arbiter.sv
// approx_mul_arbiter: shares one pipelined 16x16 multiplier among NREQ requesters.
// Round-robin grant, registered operands, a {valid,index} tag pipeline that tracks
// products in flight, and a one-entry response buffer per requester. A requester
// may have only one operation outstanding: pending[i] covers the whole path from
// accept until its response is consumed.
module approx_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [32*NREQ-1:0]   rsp_data,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    input  logic [31:0]          mul_out,
    output logic                 mul_reset,
    output logic                 busy,
    output logic [31:0]          op_count
);

    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NSTG = MUL_LAT + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    logic [NREQ-1:0]        pending_q, pending_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [15:0]            mul_a_q, mul_a_d;
    logic [15:0]            mul_b_q, mul_b_d;
    logic [NSTG-1:0]        tag_vld_q, tag_vld_d;
    logic [IW-1:0]          tag_idx_q [NSTG];
    logic [IW-1:0]          tag_idx_d [NSTG];
    logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [NREQ-1:0][31:0]  rsp_data_q, rsp_data_d;
    logic [31:0]            op_count_q, op_count_d;

    logic [NREQ-1:0]        eligible;
    logic [NREQ-1:0]        grant;
    logic [IW-1:0]          grant_idx;
    logic                   arb_found;
    logic [IW:0]            arb_sum;
    logic                   accept;
    logic [NREQ-1:0]        consume;

    assign eligible = req_valid & ~pending_q;
    assign accept   = |grant;

    // Round-robin search over eligible requesters starting at the pointer; no grant in reset.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        arb_found = 1'b0;
        arb_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            arb_sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (arb_sum >= (IW+1)'(NREQ)) begin
                arb_sum = arb_sum - (IW+1)'(NREQ);
            end
            if (!arb_found && eligible[arb_sum[IW-1:0]]) begin
                arb_found = 1'b1;
                grant_idx = arb_sum[IW-1:0];
            end
        end
        if (arb_found && resetn) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Next state: issue, tag shift, response write-back/consume, pending and counters.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        op_count_d  = op_count_q;
        rsp_data_d  = rsp_data_q;
        consume     = rsp_valid_q & rsp_ready;
        pending_d   = (pending_q & ~consume) | grant;
        rsp_valid_d = rsp_valid_q & ~consume;

        tag_vld_d    = '0;
        tag_vld_d[0] = accept;
        tag_idx_d[0] = grant_idx;
        for (int s = 1; s < NSTG; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_idx_d[s] = tag_idx_q[s-1];
        end

        // The oldest tag lines up with the product the multiplier is presenting now.
        if (tag_vld_q[NSTG-1]) begin
            rsp_valid_d[tag_idx_q[NSTG-1]] = 1'b1;
            rsp_data_d[tag_idx_q[NSTG-1]]  = mul_out;
        end

        // Operands only move on accept so the multiplier inputs stay quiet when idle.
        if (accept) begin
            mul_a_d    = req_a[16*grant_idx +: 16];
            mul_b_d    = req_b[16*grant_idx +: 16];
            rr_ptr_d   = (grant_idx == LAST_IDX) ? '0 : grant_idx + IW'(1);
            op_count_d = op_count_q + 32'd1;
        end
    end

    // State registers; reset drops everything in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            tag_vld_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            op_count_q  <= '0;
            for (int s = 0; s < NSTG; s++) begin
                tag_idx_q[s] <= '0;
            end
        end else begin
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            tag_vld_q   <= tag_vld_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            op_count_q  <= op_count_d;
            for (int s = 0; s < NSTG; s++) begin
                tag_idx_q[s] <= tag_idx_d[s];
            end
        end
    end

    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_reset = ~resetn;
    assign busy      = |pending_q;
    assign op_count  = op_count_q;

`ifndef SYNTHESIS
    // A product landing on a buffer that still holds an unconsumed result means pending was bypassed.
    a_no_overwrite: assert property (@(posedge clk) disable iff (!resetn)
        tag_vld_q[NSTG-1] |-> !rsp_valid_q[tag_idx_q[NSTG-1]]);

    // At most one grant per cycle, and only to a requester that is asking.
    a_grant_legal: assert property (@(posedge clk) disable iff (!resetn)
        $onehot0(grant) && ((grant & ~req_valid) == '0));
`endif

endmodule
